// File: rtl/blit_pkg.sv
// Shared types and screen/ROM defaults for the blitter and the VGA adapter.
package blit_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int SCR_W_DEF   = 160;
  localparam int SCR_H_DEF   = 120;
  localparam int ROM_LAT_DEF = 2;
endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register carrying {col, row, valid} alongside the ROM read.
module blit_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge reset) begin
          if (reset) q <= '0;
          else       q <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge reset) begin
          if (reset) q <= '0;
          else       q <= g_stage[gi-1].q;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q;
endmodule

// File: rtl/tile_blitter.sv
// Copies a W x H image from ROM to the framebuffer at a runtime origin, one pixel per clock, with clipping.
// Optional TILE_BLITTER_COLOUR_KEY_EN adds key_rgb: pixels matching it are not written.
module tile_blitter
  import blit_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int ADDR_W  = 16,
  parameter int RGB_W   = 24,
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [X_W-1:0]    origin_x,
  input  logic [Y_W-1:0]    origin_y,
  input  logic [X_W-1:0]    img_w,
  input  logic [Y_W-1:0]    img_h,
`ifdef TILE_BLITTER_COLOUR_KEY_EN
  input  logic [RGB_W-1:0]  key_rgb,
`endif
  input  logic [RGB_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              vga_we,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int DL_W  = X_W + Y_W + 1;
  localparam logic [X_W:0] SCR_X = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] SCR_Y = (Y_W+1)'(SCR_H);

  state_t            state, state_next;
  logic [X_W-1:0]    ox_reg, w_reg, col_reg, col_next;
  logic [Y_W-1:0]    oy_reg, h_reg, row_reg, row_next;
  logic [ADDR_W-1:0] addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              latch, last_pix;

  assign last_pix = (col_reg == w_reg - X_W'(1)) && (row_reg == h_reg - Y_W'(1));

  always_comb begin
    state_next = state;
    col_next   = col_reg;
    row_next   = row_reg;
    addr_next  = rom_addr;
    cnt_next   = cnt_reg;
    latch      = 1'b0;
    case (state)
      IDLE: if (start) begin
        latch = 1'b1;
        // A zero-area request completes without touching the ROM address.
        if (img_w == '0 || img_h == '0) begin
          state_next = DONE;
        end else begin
          state_next = ISSUE;
          col_next   = '0;
          row_next   = '0;
          addr_next  = base_addr;
        end
      end
      ISSUE: begin
        if (last_pix) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          addr_next = rom_addr + ADDR_W'(1);
          if (col_reg == w_reg - X_W'(1)) begin
            col_next = '0;
            row_next = row_reg + Y_W'(1);
          end else begin
            col_next = col_reg + X_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_reg == CNT_W'(ROM_LAT - 1)) state_next = DONE;
        else                                cnt_next   = cnt_reg + CNT_W'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ox_reg   <= '0;
      oy_reg   <= '0;
      w_reg    <= '0;
      h_reg    <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      cnt_reg  <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      col_reg  <= col_next;
      row_reg  <= row_next;
      cnt_reg  <= cnt_next;
      rom_addr <= addr_next;
      busy     <= (state_next == ISSUE) || (state_next == DRAIN);
      done     <= (state_next == DONE);
      if (latch) begin
        ox_reg <= origin_x;
        oy_reg <= origin_y;
        w_reg  <= img_w;
        h_reg  <= img_h;
      end
    end
  end

  // The tuple enters alongside the address it describes, so it emerges as rom_data arrives.
  logic [DL_W-1:0] dl_in, dl_out;
  logic [X_W-1:0]  d_col;
  logic [Y_W-1:0]  d_row;
  logic            d_valid;

  assign dl_in = {col_next, row_next, state_next == ISSUE};
  assign {d_col, d_row, d_valid} = dl_out;

  blit_delay_line #(.DEPTH(ROM_LAT), .WIDTH(DL_W)) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (dl_in),
    .dout  (dl_out)
  );

  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic         clipped, keyed, we_next;

  assign x_sum   = {1'b0, ox_reg} + {1'b0, d_col};
  assign y_sum   = {1'b0, oy_reg} + {1'b0, d_row};
  assign clipped = x_sum[X_W] || y_sum[Y_W] || (x_sum >= SCR_X) || (y_sum >= SCR_Y);

`ifdef TILE_BLITTER_COLOUR_KEY_EN
  logic [RGB_W-1:0] key_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      key_reg <= '0;
    else if (latch) key_reg <= key_rgb;
  end
  assign keyed = (rom_data == key_reg);
`else
  assign keyed = 1'b0;
`endif

  assign we_next = d_valid && !clipped && !keyed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x   <= '0;
      vga_y   <= '0;
      vga_rgb <= '0;
      vga_we  <= 1'b0;
    end else begin
      vga_we <= we_next;
      if (we_next) begin
        vga_x   <= x_sum[X_W-1:0];
        vga_y   <= y_sum[Y_W-1:0];
        vga_rgb <= rom_data;
      end
    end
  end
endmodule

// File: tb/tb_tile_blitter.sv
// Randomised bench for tile_blitter against a per-pixel reference schedule (define TILE_BLITTER_COLOUR_KEY_EN to test keying).
module tb_tile_blitter;
  localparam int LAT   = 2;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int TMAX  = 20480;
`ifdef TILE_BLITTER_COLOUR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  origin_x = '0, origin_y = '0, img_w = '0, img_h = '0;
  logic [23:0] key_rgb = '0, rom_data;
  logic [15:0] rom_addr;
  logic [7:0]  vga_x, vga_y;
  logic [23:0] vga_rgb;
  logic        vga_we, busy, done;

  int errors = 0, checks = 0;

  tile_blitter #(.ROM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .origin_x(origin_x), .origin_y(origin_y), .img_w(img_w), .img_h(img_h),
`ifdef TILE_BLITTER_COLOUR_KEY_EN
    .key_rgb(key_rgb),
`endif
    .rom_data(rom_data), .rom_addr(rom_addr), .vga_x(vga_x), .vga_y(vga_y),
    .vga_rgb(vga_rgb), .vga_we(vga_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [15:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8], a[7:0] + 8'h3C};
  endfunction

  // ROM with one internal register stage: data is sampled two edges after the address changes.
  logic [23:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom_f(rom_addr);
  assign rom_data = rom_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference schedule indexed by cycles after the accepting edge.
  logic        e_we  [TMAX];
  logic [7:0]  e_x   [TMAX];
  logic [7:0]  e_y   [TMAX];
  logic [23:0] e_rgb [TMAX];
  logic [7:0]  held_x = '0, held_y = '0;
  logic [23:0] held_rgb = '0;
  logic [15:0] held_addr = '0;

  task automatic run_job(input logic [15:0] b, input logic [7:0] ox, input logic [7:0] oy,
                         input logic [7:0] w, input logic [7:0] h, input bit dbl,
                         input logic [23:0] key);
    int n, tdone, nw, seen, xi, yi, off;
    logic [15:0] a, exp_a;
    logic [23:0] rgb;
    bit wr;
    n     = int'(w) * int'(h);
    tdone = (n == 0) ? 0 : n + LAT;
    nw    = 0;
    seen  = 0;
    for (int t = 0; t <= tdone; t++) e_we[t] = 1'b0;
    for (int k = 0; k < n; k++) begin
      xi  = int'(ox) + k % int'(w);
      yi  = int'(oy) + k / int'(w);
      a   = b + 16'(k);
      rgb = rom_f(a);
      wr  = (xi < SCR_W) && (yi < SCR_H) && !(KEY_EN && rgb == key);
      e_we[k+LAT]  = wr;
      e_x[k+LAT]   = 8'(xi);
      e_y[k+LAT]   = 8'(yi);
      e_rgb[k+LAT] = rgb;
      if (wr) nw++;
    end
    base_addr = b; origin_x = ox; origin_y = oy; img_w = w; img_h = h; key_rgb = key;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom); origin_x = 8'($urandom); origin_y = 8'($urandom);
    img_w = 8'($urandom); img_h = 8'($urandom); key_rgb = 24'($urandom);
    for (int t = 0; t <= tdone; t++) begin
      if (e_we[t]) begin
        held_x = e_x[t]; held_y = e_y[t]; held_rgb = e_rgb[t];
      end
      off   = (t < n) ? t : n - 1;
      exp_a = (n == 0) ? held_addr : b + 16'(off);
      check_eq("vga_we", 32'(vga_we), 32'(e_we[t]));
      check_eq("vga_x", 32'(vga_x), 32'(held_x));
      check_eq("vga_y", 32'(vga_y), 32'(held_y));
      check_eq("vga_rgb", 32'(vga_rgb), 32'(held_rgb));
      check_eq("rom_addr", 32'(rom_addr), 32'(exp_a));
      check_eq("busy", 32'(busy), 32'(t < tdone));
      check_eq("done", 32'(done), 32'(t == tdone));
      if (vga_we) seen++;
      if (dbl && t == 1) start = 1'b1;
      if (dbl && t == 2) start = 1'b0;
      if (t < tdone) begin
        @(posedge clk); #1;
      end
    end
    if (n != 0) held_addr = b + 16'(n - 1);
    check_eq("write_count", 32'(seen), 32'(nw));
    @(posedge clk); #1;
    check_eq("idle_we", 32'(vga_we), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    $display("job base=%04h org=(%0d,%0d) size=%0dx%0d dbl=%0d writes=%0d", b, ox, oy, w, h, dbl, seen);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, "_x"}, 32'(vga_x), 32'd0);
    check_eq({tag, "_y"}, 32'(vga_y), 32'd0);
    check_eq({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
    check_eq({tag, "_we"}, 32'(vga_we), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic reset_mid_blit();
    base_addr = 16'h0300; origin_x = 8'd0; origin_y = 8'd0; img_w = 8'd4; img_h = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    held_x = '0; held_y = '0; held_rgb = '0; held_addr = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_eq("post_reset_we", 32'(vga_we), 32'd0);
      check_eq("post_reset_busy", 32'(busy), 32'd0);
    end
    $display("reset mid-blit at E3 checked");
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_job(16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b0, 24'h0);
    run_job(16'h0200, 8'd158, 8'd0, 8'd4, 8'd1, 1'b0, 24'h0);
    run_job(16'h1234, 8'd5, 8'd5, 8'd0, 8'd3, 1'b0, 24'h0);
    run_job(16'h4321, 8'd5, 8'd5, 8'd3, 8'd0, 1'b0, 24'h0);
    reset_mid_blit();
    run_job(16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b1, 24'h0);
    run_job(16'hFFFE, 8'd0, 8'd0, 8'd4, 8'd1, 1'b0, 24'h0);
    run_job(16'h0400, 8'd10, 8'd10, 8'd2, 8'd1, 1'b0, rom_f(16'h0400));
    run_job(16'h0500, 8'd250, 8'd115, 8'd12, 8'd10, 1'b0, 24'h0);
    for (int j = 0; j < 25; j++) begin
      run_job(16'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 20)), 8'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
              24'($urandom));
    end
    run_job(16'h0000, 8'd0, 8'd0, 8'd160, 8'd120, 1'b0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_blitter.md
Name: tile_blitter

Overview:
- Parametrised successor to the full-screen map drawer.
- Copies a rectangular W x H image out of the graphics ROM into the VGA framebuffer, placed at a runtime origin.
- Sustains one pixel per clock through a pipeline matched to the ROM read latency, and clips pixels that fall off-screen.
- Used for map tiles, sprites and full-screen backgrounds; the full-screen case is origin (0,0) with W x H = SCR_W x SCR_H.

Parameters:
- X_W, 8, width of x coordinates and of the runtime width input.
- Y_W, 8, width of y coordinates and of the runtime height input.
- ADDR_W, 16, ROM address width.
- RGB_W, 24, pixel colour width.
- SCR_W, 160, screen width in pixels; pixels with x >= SCR_W are clipped.
- SCR_H, 120, screen height in pixels; pixels with y >= SCR_H are clipped.
- ROM_LAT, 2, edges from a rom_addr update to the edge at which the matching rom_data is sampled; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- base_addr  in  ADDR_W  ROM address of the image's top-left pixel; sampled with start
- origin_x  in  X_W  screen x of the image's top-left pixel; sampled with start
- origin_y  in  Y_W  screen y of the image's top-left pixel; sampled with start
- img_w  in  X_W  image width in pixels; sampled with start
- img_h  in  Y_W  image height in pixels; sampled with start
- rom_data  in  RGB_W  ROM read data
- rom_addr  out  ADDR_W  ROM read address (registered)
- vga_x  out  X_W  write x coordinate
- vga_y  out  Y_W  write y coordinate
- vga_rgb  out  RGB_W  write colour
- vga_we  out  1  write enable; high for exactly one cycle per written pixel
- busy  out  1  high from the start acceptance edge until the done edge
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs and internal registers go to 0.
  - State returns to IDLE.
  - Reset mid-operation abandons the blit; no further vga_we pulses occur.
- States:
  - IDLE -> ISSUE on start, if img_w != 0 and img_h != 0.
  - IDLE -> DONE on start, if img_w == 0 or img_h == 0; no writes are issued.
  - ISSUE -> DRAIN after the last address is issued.
  - DRAIN -> DONE after ROM_LAT cycles.
  - DONE -> IDLE after one cycle.
- At the edge that accepts start (E0), latch all inputs, set col = row = 0 and set rom_addr = base_addr.
- ISSUE, every cycle:
  - rom_addr increments by 1, modulo 2^ADDR_W; wrap is permitted and not flagged.
  - col increments; at col == img_w-1, col returns to 0 and row increments.
  - The last address is base_addr + img_w*img_h - 1.
- For each issued address, the tuple {col, row, valid} enters a delay line ROM_LAT deep.
- At edge E(k+ROM_LAT), for the address issued at edge Ek:
  - vga_rgb <= rom_data
  - vga_x <= origin_x + col
  - vga_y <= origin_y + row
  - vga_we <= valid AND not clipped
- Clipping:
  - Sums are computed one bit wider than the coordinate (X_W+1 or Y_W+1).
  - A pixel is clipped if a sum carries, or if x >= SCR_W, or if y >= SCR_H.
  - Clipped pixels still consume a cycle and an address.
- Timing:
  - First write at E(ROM_LAT); last write at E(ROM_LAT + img_w*img_h - 1).
  - done pulses and busy falls at the following edge.
- vga_x, vga_y and vga_rgb hold their last values while vga_we is low.
- start while busy is ignored; inputs changing mid-blit have no effect.
- start arriving in the DONE cycle is ignored; a new start is accepted only in IDLE.

Optional Feature:
- Macro: TILE_BLITTER_COLOUR_KEY_EN.
- Defined:
  - Adds input port key_rgb (RGB_W), sampled with start.
  - Any pixel with rom_data == key_rgb has vga_we suppressed (transparent).
  - Timing, addresses and done are unchanged.
- Undefined: port absent; every in-bounds pixel is written.

Decomposition:
- Package blit_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the default SCR_W and SCR_H constants, shared with the VGA adapter;
  - the ROM_LAT default.
- Sub-module blit_delay_line: parametrised shift register (DEPTH = ROM_LAT, WIDTH = X_W+Y_W+1) carrying {col, row, valid}; reset clears the valid bits.

Test Plan:
- Basic blit: ROM_LAT=2, base 0x0100, origin (10,20), 4x2 image:
  - rom_addr = 0x0100..0x0107 on consecutive cycles;
  - 8 vga_we pulses at E2..E9, x = 10..13 then 10..13, y = 20,20,20,20,21,21,21,21, rgb matching the ROM model;
  - done at E10.
- Clipping: origin (158,0), 4x1, SCR_W=160:
  - writes only at x = 158 and 159;
  - 4 addresses still issued; done at E(ROM_LAT+4).
- Degenerate sizes: img_w=0 -> done one cycle after start, no vga_we, no rom_addr change; repeat with img_h=0.
- Reset and start-while-busy:
  - Assert reset at E3 of a 4x2 blit -> all outputs 0 immediately, no later vga_we.
  - A second start during a blit -> ignored; exactly 8 writes.
- Address wrap: base 0xFFFE, 4x1 -> addresses FFFE, FFFF, 0000, 0001.
- Colour key (TILE_BLITTER_COLOUR_KEY_EN defined): key 0xFF00FF, ROM row {0xFF00FF, 0x123456} -> only the second pixel is written; done timing unchanged.
